// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI register target.
package spi_target_pkg;

    localparam int NREG          = 8;
    localparam int ADDR_W        = 3;
    localparam int CMD_WRITE_BIT = 7;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(7);

    // Frame state of the target; exported on the debug port as well.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CMD      = 2'd1,
        ST_DATA     = 2'd2,
        ST_WAIT_CSB = 2'd3
    } state_t;

endpackage

// File: rtl/spi_target_regs_if.sv
// Pin-level bundle between the wrapper's SPI master and the register target.
//
// Handshake: wr_stb_o is a one-cycle valid with no ready (the target never
// stalls). In the cycle wr_stb_o is high, wr_addr_o names the register just
// written and regs_o already holds the new byte. All SPI inputs are
// asynchronous to the core clock; dbg_state mirrors the frame FSM.
interface spi_target_regs_if;
    import spi_target_pkg::*;

    logic                  spi_csb_i;
    logic                  spi_sck_i;
    logic                  spi_mosi_i;
    logic                  spi_miso_o;
    logic                  spi_misoenb_o;
    logic [7:0]            status_i;
    logic [8*(NREG-1)-1:0] regs_o;
    logic                  wr_stb_o;
    logic [ADDR_W-1:0]     wr_addr_o;
    state_t                dbg_state;

    modport slave (
        input  spi_csb_i, spi_sck_i, spi_mosi_i, status_i,
        output spi_miso_o, spi_misoenb_o, regs_o, wr_stb_o, wr_addr_o, dbg_state
    );

    modport master (
        output spi_csb_i, spi_sck_i, spi_mosi_i, status_i,
        input  spi_miso_o, spi_misoenb_o, regs_o, wr_stb_o, wr_addr_o, dbg_state
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses. A pin edge shows
// up as a one-cycle pulse three core cycles later. All flops reset to 0, so
// a high input seen after reset produces a rise pulse and a low input does
// not produce a fall.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronise the pin and compare against its previous value.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise   <= sync_q & ~prev_q;
            fall   <= ~sync_q & prev_q;
        end
    end

    assign sync = sync_q;

endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 target giving the wrapper's SPI master access to seven control
// registers and one read-only status byte. Lines are oversampled in the core
// clock domain; byte 0 of a frame is the command, later bytes are data with
// an auto-incrementing, wrapping address.
module spi_target_regs
    import spi_target_pkg::*;
(
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    spi_target_regs_if.slave bus
);

    logic csb_sync, csb_rise, csb_fall;
    logic sck_rise, sck_fall, sck_sync_unused;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge u_csb (
        .clk (wb_clk_i), .rst (wb_rst_i), .din (bus.spi_csb_i),
        .sync(csb_sync), .rise(csb_rise), .fall(csb_fall)
    );

    spi_sync_edge u_sck (
        .clk (wb_clk_i), .rst (wb_rst_i), .din (bus.spi_sck_i),
        .sync(sck_sync_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge u_mosi (
        .clk (wb_clk_i), .rst (wb_rst_i), .din (bus.spi_mosi_i),
        .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t              state, state_nxt;
    logic [2:0]          bit_cnt;
    logic [6:0]          shift_in;
    logic [7:0]          byte_in;
    logic [ADDR_W-1:0]   addr;
    logic                is_write;
    logic                load_pending;
    logic [6:0]          shift_out;
    logic                miso_q;
    logic [7:0]          rd_byte;
    logic [7:0]          regs [NREG-1];
    logic [8*(NREG-1)-1:0] regs_flat;
    logic                wr_stb;
    logic [ADDR_W-1:0]   wr_addr;
    logic                in_frame;
    logic                byte_done;

    // A CSB rise pulse outranks any SCK edge in the same cycle.
    assign in_frame  = (state == ST_CMD) || (state == ST_DATA);
    assign byte_in   = {shift_in, mosi_sync};
    assign byte_done = in_frame && !csb_rise && sck_rise && (bit_cnt == 3'd7);

    // Frame state register; reset parks in WAIT_CSB so a frame cut by reset
    // is ignored until CSB is seen high.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= ST_WAIT_CSB;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (csb_rise) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (csb_fall)  state_nxt = ST_CMD;
                ST_CMD:      if (byte_done) state_nxt = ST_DATA;
                ST_DATA:     state_nxt = ST_DATA;
                ST_WAIT_CSB: if (csb_sync)  state_nxt = ST_IDLE;
                default:     state_nxt = ST_WAIT_CSB;
            endcase
        end
    end

    // Read source for the current address: status at the top slot.
    always_comb begin
        rd_byte = bus.status_i;
        for (int i = 0; i < NREG - 1; i++) begin
            if (addr == ADDR_W'(i)) rd_byte = regs[i];
        end
    end

    // Bit counting, command decode, address stepping and MISO shifting.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bit_cnt      <= '0;
            shift_in     <= '0;
            addr         <= '0;
            is_write     <= 1'b0;
            load_pending <= 1'b0;
            shift_out    <= '0;
            miso_q       <= 1'b0;
        end else if (!in_frame || csb_rise) begin
            bit_cnt      <= '0;
            load_pending <= 1'b0;
            shift_out    <= '0;
            miso_q       <= 1'b0;
        end else if (sck_rise) begin
            shift_in <= byte_in[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                load_pending <= 1'b1;
                if (state == ST_CMD) begin
                    is_write <= byte_in[CMD_WRITE_BIT];
                    addr     <= byte_in[ADDR_W-1:0];
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
            end
        end else if (sck_fall) begin
            load_pending <= 1'b0;
            if (load_pending && !is_write) begin
                shift_out <= rd_byte[6:0];
                miso_q    <= rd_byte[7];
            end else begin
                shift_out <= {shift_out[5:0], 1'b0};
                miso_q    <= shift_out[6];
            end
        end
    end

    // Register file write and strobe; bytes aimed at the status slot vanish.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NREG - 1; i++) regs[i] <= '0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (byte_done && state == ST_DATA && is_write && addr != STATUS_ADDR) begin
                for (int i = 0; i < NREG - 1; i++) begin
                    if (addr == ADDR_W'(i)) regs[i] <= byte_in;
                end
                wr_stb  <= 1'b1;
                wr_addr <= addr;
            end
        end
    end

    // Flatten registers for the output bus, register 0 in the low byte.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREG - 1; i++) regs_flat[i*8 +: 8] = regs[i];
    end

    assign bus.regs_o        = regs_flat;
    assign bus.wr_stb_o      = wr_stb;
    assign bus.wr_addr_o     = wr_addr;
    assign bus.spi_misoenb_o = !in_frame;
    assign bus.spi_miso_o    = in_frame & miso_q;
    assign bus.dbg_state     = state;

endmodule

// File: doc/spi_target_regs.md
# spi_target_regs

SPI target (mode 0) that answers the SPI master pins the user project wrapper drives (`spi_csb`, `spi_sck`, `spi_sdo`, `spi_sdi`). It oversamples the SPI lines in the core clock domain and gives the master read/write access to eight 8-bit registers. Registers 0–6 are control registers. Register 7 is a read-only status byte. It is the far end of the wrapper's SPI master port and is used for bring-up and loopback of that port.

## Interface
- `NREG` – 8 – number of registers. Fixed; the address is 3 bits.
- `wb_clk_i` – in – 1 – core clock; all logic is on its rising edge.
- `wb_rst_i` – in – 1 – synchronous, active-high reset.
- `spi_csb_i` – in – 1 – chip select, active low; asynchronous to `wb_clk_i`.
- `spi_sck_i` – in – 1 – SPI clock, idles low; asynchronous.
- `spi_mosi_i` – in – 1 – master-to-target data.
- `spi_miso_o` – out – 1 – target-to-master data. Reset value 0.
- `spi_misoenb_o` – out – 1 – MISO output enable, active low. Reset value 1.
- `status_i` – in – 8 – value returned when register 7 is read.
- `regs_o` – out – 56 – registers 0–6 concatenated, register 0 in [7:0]. Reset value 0.
- `wr_stb_o` – out – 1 – one-cycle pulse when a register is written. Reset value 0.
- `wr_addr_o` – out – 3 – address of the last write. Reset value 0.

## Operation
- **Synchronisation:** CSB, SCK and MOSI each pass through a 2-flop synchroniser. SCK rising and falling edges are detected on the synchronised signal.
- **Frame:** starts when synchronised CSB falls. Bits are MSB first.
  - Byte 0 is the command: bit7 = 1 for write, 0 for read. Bits[2:0] are the start address. Bits[6:3] are ignored.
  - Each later byte is a data byte. The address increments after every data byte and wraps from 7 to 0.
- **Sampling and driving:** MOSI is sampled on SCK rising edges. MISO is updated on SCK falling edges.
- **States:** IDLE, CMD, DATA, WAIT_CSB.
  - IDLE → CMD when CSB falls.
  - CMD → DATA after the 8th rising edge.
  - DATA stays in DATA until CSB rises.
  - Any state → IDLE when CSB rises.
  - WAIT_CSB is entered from reset if CSB is low. It returns to IDLE only when CSB is high.
- **Write:** on the 8th rising edge of each data byte:
  - for address 0–6, the register is updated, `wr_stb_o` pulses and `wr_addr_o` is set;
  - for address 7, the byte is discarded and there is no strobe.
  - The address increments in both cases.
- **Read:** on the falling edge after the 8th command bit, the shift register loads reg[addr], or `status_i` for address 7, and drives its MSB onto MISO. Each data byte reloads from the incremented address on the falling edge after its 8th bit. MOSI is ignored during a read.
- **MISO enable:** `spi_misoenb_o` = 0 while the state is CMD or DATA. Otherwise it is 1 and `spi_miso_o` is 0.
- **Partial byte:** if CSB rises mid-byte, the partial byte is discarded with no write. The bit counter and state clear.
- **Reset mid-frame:** registers clear and the state goes to WAIT_CSB. The remainder of that frame has no effect.

## Timing
- Latency from a pin edge to the internal edge-detect pulse is 3 `wb_clk_i` cycles.
- The SCK high and low phases must each be ≥ 4 `wb_clk_i` cycles; SCK ≤ `wb_clk_i`/8.
- There must be ≥ 4 cycles from CSB fall to the first SCK rise, and from the last SCK fall to CSB rise.
- **Write timing:** `regs_o` and `wr_addr_o` update, and `wr_stb_o` is high, in the cycle after the internal rising-edge pulse for bit 8. That is 4 cycles after the pin edge.
- **MISO timing:** `spi_miso_o` changes in the cycle after the internal falling-edge pulse. That is 4 cycles after the pin edge, which is within the half period.
- **Status sampling:** `status_i` is sampled in the cycle of the reload.
- **CSB and SCK together:** if a CSB-rise pulse and an SCK-edge pulse occur in the same cycle, CSB wins.

## Structure
- **Shared package `spi_target_pkg`:**
  - state enum;
  - `CMD_WRITE_BIT` = 7;
  - `ADDR_W` = 3;
  - `STATUS_ADDR` = 7.
- **Sub-module `spi_sync_edge`:** 2-flop synchroniser plus rise/fall pulse outputs. It is instantiated once per SPI input; edge outputs are used for SCK and CSB.

## Test plan
- **Write burst with wrap:**
  - Stimulus: write to registers 5, 6, 7, 0. CSB low; bytes 0x85, 0x11, 0x22, 0x33, 0x44; CSB high.
  - Response: reg5 = 0x11, reg6 = 0x22, reg0 = 0x44. The byte to register 7 is dropped.
  - There are three `wr_stb_o` pulses, with `wr_addr_o` = 5, 6, 0.
- **Read with status:**
  - Stimulus: reg6 preloaded to 0x5A, `status_i` = 0xC3. Send command 0x06, then 3 dummy bytes.
  - Response: MISO returns 0x5A, 0xC3, then reg0.
  - `spi_misoenb_o` is 0 only while CSB is low.
- **Abort mid-byte:** write command 0x82, then 5 data bits, then CSB high. Response: reg2 unchanged and no `wr_stb_o` pulse. A following full write of 0x82, 0x7E sets reg2 = 0x7E.
- **Reset mid-frame:**
  - Stimulus: write 0x81 plus 4 bits, then assert `wb_rst_i` for 1 cycle, then finish the byte as 0xFF.
  - Response: all of `regs_o` = 0 and no strobe.
  - The next frame, after CSB goes high, works normally.
- **Minimum SCK period:** 8-cycle SCK period, random write then read-back of all 7 registers. Response: data matches with no bit slip.
- **Idle outputs:** after reset with CSB high, `spi_miso_o` = 0, `spi_misoenb_o` = 1 and `wr_stb_o` = 0. SCK toggling with CSB high changes nothing.
